icache_refill: RTL and testbench
================================

# icache_refill

Refill engine between the instruction cache and the boot ROM in the rv32 SoC. On an ICache miss it fetches one full cache line from the synchronous ROM, critical word first with wrap-around. It streams the words back to the ICache tagged with their line index. A redirect or flush from the fetch stage can abort it at any time.

## Interface
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: ROM word width.
- `LINE_WORDS`, default 4: words per cache line. Must be a power of two, ≥2.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high. Asserting it forces IDLE and all outputs to 0 immediately.
- `miss_req_i` in 1: ICache miss request. Held high until `miss_ack_o`.
- `miss_addr_i` in ADDR_W: byte address of the missing fetch. Bits [1:0] are ignored.
- `abort_i` in 1: fetch redirect or flush. Cancels the refill in progress.
- `miss_ack_o` out 1: one-cycle pulse; the request has been accepted.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `rom_en_o` out 1: ROM read enable.
- `rom_addr_o` out ADDR_W: ROM word-aligned byte address.
- `rom_data_i` in DATA_W: ROM read data, valid exactly one cycle after `rom_en_o`.
- `refill_valid_o` out 1: refill word valid.
- `refill_data_o` out DATA_W: refill word.
- `refill_idx_o` out log2(LINE_WORDS): word index within the line.
- `refill_last_o` out 1: marks the final word of the line.

## Operation
- States:
  - IDLE: wait for a request.
  - ISSUE: issue ROM reads for LINE_WORDS cycles.
  - DRAIN: 2 cycles, to collect the tail of the ROM and output pipe.
- Line base address = `miss_addr_i` & ~(LINE_WORDS*4−1).
- Critical word index c = `miss_addr_i`[log2(LINE_WORDS)+1:2].
- IDLE → ISSUE when `miss_req_i`=1 and `abort_i`=0. In the same edge, register the base address and c, and clear the issue counter k.
- In ISSUE, each cycle:
  - `rom_en_o`=1.
  - `rom_addr_o` = base + 4·((c+k) mod LINE_WORDS).
  - k increments by 1.
  - ISSUE → DRAIN after the cycle with k = LINE_WORDS−1.
- Response pipe: a 1-bit valid plus index, delayed to align with `rom_data_i`. It feeds an output register that drives `refill_valid_o`, `refill_data_o` and `refill_idx_o`. The index tracks the wrapped value (c+k) mod LINE_WORDS.
- `refill_last_o` is high on the word issued at k = LINE_WORDS−1, i.e. index (c−1) mod LINE_WORDS.
- DRAIN → IDLE after 2 cycles.
- `abort_i`=1 in ISSUE or DRAIN:
  - next state is IDLE;
  - the response-pipe valid and `refill_valid_o` are cleared on that edge;
  - no further refill words are emitted;
  - in-flight ROM data is discarded.
- `abort_i` in IDLE blocks acceptance that cycle.
- `miss_req_i` while busy is ignored. There is no queueing.
- Address arithmetic wraps modulo 2^ADDR_W. Index arithmetic wraps modulo LINE_WORDS.

## Timing
- Reset values: state IDLE; k=0; every output 0.
- For a request sampled at the end of cycle N (LINE_WORDS=L):
  - `miss_ack_o` and the first `rom_en_o` in cycle N+1.
  - ROM reads issued in cycles N+1..N+L.
  - `refill_valid_o` high in cycles N+3..N+L+2, contiguous with no bubbles.
  - `refill_last_o` high in cycle N+L+2.
  - `busy_o` high in cycles N+1..N+L+2.
  - IDLE in cycle N+L+3.
- For L=4, a back-to-back request still high in N+7 is acked in N+8.
- Abort sampled at the end of cycle M: `refill_valid_o`=0 and `busy_o`=0 from M+1. A new request can be sampled in M+1.
- Abort coincident with the final `refill_valid_o` word: that word is still presented in its cycle; nothing follows it.

## Structure
- Shared package `icache_pkg`:
  - state enum (IDLE/ISSUE/DRAIN);
  - `LINE_WORDS`;
  - line offset width;
  - the index type, shared with the ICache tag/data arrays.
- Single module; no sub-module. The response pipe is two register stages inline.

## Test plan
- Aligned miss: `miss_addr_i`=0x0000_0040, L=4 → ROM addresses 0x40, 0x44, 0x48, 0x4C in N+1..N+4. Refill indices 0, 1, 2, 3 in N+3..N+6, with last at idx 3.
- Wrap miss: `miss_addr_i`=0x0000_0048 → ROM addresses 0x48, 0x4C, 0x40, 0x44. Indices 2, 3, 0, 1, with last on idx 1. Data matches ROM contents.
- Abort mid-ISSUE: abort sampled at the end of N+2 → `rom_en_o`=0 from N+3, no `refill_valid_o` at or after N+3, IDLE in N+3.
- Back-to-back: `miss_req_i` held for two lines, 0x00 then 0x10 → second ack in N+8. No `refill_valid_o` overlap or gap within each line.
- Reset mid-refill: assert `rst` asynchronously during ISSUE → all outputs 0 immediately. After release, a miss to 0x20 refills correctly.
- Request while busy with a different address: it is ignored until IDLE, then acked with its own address.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared ICache definitions: refill FSM states, line geometry and the word
// index type used by the refill engine and the ICache tag/data arrays.
// Latency: n/a (types and constants only). Backpressure: n/a.
package icache_pkg;

  // Words per cache line (power of two, >= 2).
  localparam int LINE_WORDS = 4;

  // Word-index width and byte-offset width of one line.
  localparam int IDX_W      = $clog2(LINE_WORDS);
  localparam int LINE_OFF_W = IDX_W + 2;

  // Word index within a line.
  typedef logic [IDX_W-1:0] idx_t;

  // Refill engine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/icache_refill.sv
// ICache line refill from the synchronous boot ROM, critical word first with wrap-around.
// Latency: ack and first ROM read 1 cycle after the request; first refill word 3 cycles after; line done after LINE_WORDS+2.
// Backpressure: none downstream (the ICache always sinks words); requests while busy are ignored, abort cancels at any time.
//
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   miss_req_i/addr_i   - miss request (held until miss_ack_o) and byte address
//   abort_i             - fetch redirect/flush, cancels the refill in progress
//   miss_ack_o, busy_o  - one-cycle acceptance pulse; engine not idle
//   rom_en_o/addr_o     - ROM read port; rom_data_i valid one cycle after rom_en_o
//   refill_*_o          - refill word stream: valid, data, index in line, last word
module icache_refill #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = icache_pkg::LINE_WORDS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_req_i,
  input  logic [ADDR_W-1:0]             miss_addr_i,
  input  logic                          abort_i,
  output logic                          miss_ack_o,
  output logic                          busy_o,
  output logic                          rom_en_o,
  output logic [ADDR_W-1:0]             rom_addr_o,
  input  logic [DATA_W-1:0]             rom_data_i,
  output logic                          refill_valid_o,
  output logic [DATA_W-1:0]             refill_data_o,
  output logic [$clog2(LINE_WORDS)-1:0] refill_idx_o,
  output logic                          refill_last_o
);

  import icache_pkg::*;

  localparam int IW = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [IW-1:0]     K_LAST   = IW'(LINE_WORDS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_issue;

  logic [ADDR_W-1:0] r_base;
  logic [IW-1:0]     r_crit;
  logic [IW-1:0]     r_k;
  logic              r_drn;
  logic              r_ack;

  // Response pipe stage aligned with rom_data_i.
  logic              r_p_vld;
  logic [IW-1:0]     r_p_idx;
  logic              r_p_last;

  // Output register stage.
  logic              r_o_vld;
  logic [DATA_W-1:0] r_o_dat;
  logic [IW-1:0]     r_o_idx;
  logic              r_o_last;

  logic [IW-1:0]     w_iss_idx;
  logic [ADDR_W-1:0] w_iss_addr;
  logic              w_p_keep;

  // Index wraps naturally in IW bits, giving (c+k) mod LINE_WORDS.
  assign w_iss_idx  = r_crit + r_k;
  // Base is line-aligned, so adding the word offset never carries into the
  // tag; the sum still wraps modulo 2^ADDR_W.
  assign w_iss_addr = r_base + ADDR_W'({w_iss_idx, 2'b00});
  assign w_issue    = (r_state == ISSUE);
  // An abort on the same edge discards anything in the pipe.
  assign w_p_keep   = r_p_vld && !abort_i;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (miss_req_i && !abort_i) begin
          w_state_nxt = ISSUE;
          w_accept    = 1'b1;
        end
      end
      ISSUE: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
        end else if (r_k == K_LAST) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Two cycles: one for the last ROM read, one for the output register.
        if (abort_i || r_drn) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request capture and issue/drain counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_crit <= '0;
      r_k    <= '0;
      r_drn  <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_base <= miss_addr_i & ~OFF_MASK;
        r_crit <= miss_addr_i[IW+1:2];
        r_k    <= '0;
      end else if (w_issue) begin
        // Wraps back to 0 after the last issue, ready for the next line.
        r_k <= abort_i ? '0 : r_k + 1'b1;
      end
      r_drn <= (r_state == DRAIN) && !abort_i && !r_drn;
    end
  end

  // Response pipe and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_vld  <= 1'b0;
      r_p_idx  <= '0;
      r_p_last <= 1'b0;
      r_o_vld  <= 1'b0;
      r_o_dat  <= '0;
      r_o_idx  <= '0;
      r_o_last <= 1'b0;
    end else begin
      r_p_vld  <= w_issue && !abort_i;
      r_p_idx  <= w_issue ? w_iss_idx : '0;
      r_p_last <= w_issue && (r_k == K_LAST);
      r_o_vld  <= w_p_keep;
      r_o_dat  <= w_p_keep ? rom_data_i : '0;
      r_o_idx  <= w_p_keep ? r_p_idx : '0;
      r_o_last <= w_p_keep && r_p_last;
    end
  end

  assign miss_ack_o     = r_ack;
  assign busy_o         = (r_state != IDLE);
  assign rom_en_o       = w_issue;
  assign rom_addr_o     = w_issue ? w_iss_addr : '0;
  assign refill_valid_o = r_o_vld;
  assign refill_data_o  = r_o_dat;
  assign refill_idx_o   = r_o_idx;
  assign refill_last_o  = r_o_last;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill with a synchronous ROM whose contents are a
// fixed function of the address. Expected ROM address sequences are written out
// per test; indices and data follow from those addresses.
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req_i;
  logic [31:0] miss_addr_i;
  logic        abort_i;
  logic        miss_ack_o;
  logic        busy_o;
  logic        rom_en_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        refill_valid_o;
  logic [31:0] refill_data_o;
  logic [1:0]  refill_idx_o;
  logic        refill_last_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  icache_refill #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .LINE_WORDS(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .miss_req_i    (miss_req_i),
    .miss_addr_i   (miss_addr_i),
    .abort_i       (abort_i),
    .miss_ack_o    (miss_ack_o),
    .busy_o        (busy_o),
    .rom_en_o      (rom_en_o),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .refill_valid_o(refill_valid_o),
    .refill_data_o (refill_data_o),
    .refill_idx_o  (refill_idx_o),
    .refill_last_o (refill_last_o)
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Synchronous ROM: data valid the cycle after the read enable.
  always_ff @(posedge clk) begin
    if (rom_en_o) rom_data_i <= rom_fn(rom_addr_o);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Starts a request in the current cycle (N) and checks cycles N+1..N+6.
  // nxt_cyc: cycle in which a further request is raised with nxt_addr.
  // abort_cyc: cycle in which abort_i is raised (sampled at its end).
  task automatic do_line(input string tag, input logic [31:0] req,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3,
                         input int nxt_cyc, input logic [31:0] nxt_addr,
                         input int abort_cyc);
    logic [31:0] ea [4];
    logic        ab;
    ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
    miss_req_i  = 1'b1;
    miss_addr_i = req;
    chk($sformatf("%s c0 busy", tag), 32'(busy_o), 32'd0);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == abort_cyc + 1) abort_i = 1'b0;
      ab = (abort_cyc != 0) && (cyc > abort_cyc);
      chk($sformatf("%s c%0d ack",  tag, cyc), 32'(miss_ack_o),     32'(!ab && cyc == 1));
      chk($sformatf("%s c%0d busy", tag, cyc), 32'(busy_o),         32'(!ab));
      chk($sformatf("%s c%0d en",   tag, cyc), 32'(rom_en_o),       32'(!ab && cyc <= 4));
      chk($sformatf("%s c%0d vld",  tag, cyc), 32'(refill_valid_o), 32'(!ab && cyc >= 3));
      chk($sformatf("%s c%0d last", tag, cyc), 32'(refill_last_o),  32'(!ab && cyc == 6));
      if (!ab && cyc <= 4)
        chk($sformatf("%s c%0d addr", tag, cyc), rom_addr_o, ea[cyc-1]);
      if (!ab && cyc >= 3) begin
        chk($sformatf("%s c%0d idx",  tag, cyc), 32'(refill_idx_o), 32'(ea[cyc-3][3:2]));
        chk($sformatf("%s c%0d data", tag, cyc), refill_data_o, rom_fn(ea[cyc-3]));
      end
      if (cyc == 1) miss_req_i = 1'b0;
      if (cyc == nxt_cyc) begin
        miss_req_i  = 1'b1;
        miss_addr_i = nxt_addr;
      end
      if (cyc == abort_cyc) abort_i = 1'b1;
    end
  endtask

  // Next cycle must be idle with nothing being emitted.
  task automatic idle_chk(input string tag);
    @(negedge clk);
    abort_i = 1'b0;
    chk({tag, " idle busy"}, 32'(busy_o),         32'd0);
    chk({tag, " idle en"},   32'(rom_en_o),       32'd0);
    chk({tag, " idle vld"},  32'(refill_valid_o), 32'd0);
    chk({tag, " idle ack"},  32'(miss_ack_o),     32'd0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " ack"},  32'(miss_ack_o),     32'd0);
    chk({tag, " busy"}, 32'(busy_o),         32'd0);
    chk({tag, " en"},   32'(rom_en_o),       32'd0);
    chk({tag, " addr"}, rom_addr_o,          32'd0);
    chk({tag, " vld"},  32'(refill_valid_o), 32'd0);
    chk({tag, " data"}, refill_data_o,       32'd0);
    chk({tag, " idx"},  32'(refill_idx_o),   32'd0);
    chk({tag, " last"}, 32'(refill_last_o),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    miss_req_i  = 1'b0;
    miss_addr_i = 32'h0;
    abort_i     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    all_zero("reset");
    rst = 1'b0;
    idle_chk("post_reset");

    // Aligned miss and wrap misses (address bits [1:0] ignored).
    do_line("aligned", 32'h0000_0040, 32'h40, 32'h44, 32'h48, 32'h4C, 0, 32'h0, 0);
    idle_chk("aligned");
    do_line("wrap2", 32'h0000_0048, 32'h48, 32'h4C, 32'h40, 32'h44, 3, 32'h0000_0030, 0);
    idle_chk("wrap2");
    // Request raised while busy with a different address, acked once idle.
    do_line("late", 32'h0000_0030, 32'h30, 32'h34, 32'h38, 32'h3C, 0, 32'h0, 0);
    idle_chk("late");
    do_line("wrap3", 32'h0000_004F, 32'h4C, 32'h40, 32'h44, 32'h48, 0, 32'h0, 0);
    idle_chk("wrap3");
    do_line("top", 32'hFFFF_FFF4, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 0, 32'h0, 0);
    idle_chk("top");

    // Back-to-back: request held through the first line with a new address.
    do_line("b2b0", 32'h0000_0000, 32'h00, 32'h04, 32'h08, 32'h0C, 1, 32'h0000_0010, 0);
    idle_chk("b2b_gap");
    do_line("b2b1", 32'h0000_0010, 32'h10, 32'h14, 32'h18, 32'h1C, 0, 32'h0, 0);
    idle_chk("b2b1");

    // Aborts: mid-ISSUE, in DRAIN with a word pending, on the final word.
    do_line("abort_iss", 32'h0000_0040, 32'h40, 32'h44, 32'h48, 32'h4C, 0, 32'h0, 2);
    idle_chk("abort_iss");
    do_line("abort_drn", 32'h0000_0044, 32'h44, 32'h48, 32'h4C, 32'h40, 0, 32'h0, 5);
    idle_chk("abort_drn");
    do_line("abort_last", 32'h0000_0008, 32'h08, 32'h0C, 32'h00, 32'h04, 0, 32'h0, 6);
    idle_chk("abort_last");

    // Abort in IDLE blocks acceptance for that cycle only.
    miss_req_i  = 1'b1;
    miss_addr_i = 32'h0000_0040;
    abort_i     = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("idle_abort ack",  32'(miss_ack_o), 32'd0);
    chk("idle_abort busy", 32'(busy_o),     32'd0);
    do_line("after_idle_abort", 32'h0000_0040, 32'h40, 32'h44, 32'h48, 32'h4C, 0, 32'h0, 0);
    idle_chk("after_idle_abort");

    // Asynchronous reset mid-ISSUE, away from any clock edge.
    miss_req_i  = 1'b1;
    miss_addr_i = 32'h0000_0040;
    @(negedge clk);
    miss_req_i = 1'b0;
    @(negedge clk);
    chk("pre_rst en", 32'(rom_en_o), 32'd1);
    rst = 1'b1;
    #1;
    all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_line("after_rst", 32'h0000_0020, 32'h20, 32'h24, 32'h28, 32'h2C, 0, 32'h0, 0);
    idle_chk("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
